// File: rtl/median_filter_pkg.sv
// Shared types for the median filter pixel path: pixel_t, streamer FSM states,
// frame memory latency and the 24-bit word packing helpers.
package median_filter_pkg;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    HBLANK,
    DRAIN,
    DONE
  } streamer_state_t;

  localparam int MEM_LATENCY = 1;

  function automatic pixel_t unpack_pixel(input logic [23:0] word);
    pixel_t p;
    p.red   = word[23:16];
    p.green = word[15:8];
    p.blue  = word[7:0];
    return p;
  endfunction

  function automatic logic [23:0] pack_pixel(input pixel_t p);
    return {p.red, p.green, p.blue};
  endfunction

  // $clog2 collapses to 0 for a single-entry range; keep every bus at least 1 bit wide.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_valid_if.sv
// Unidirectional pixel link with a valid qualifier and no backpressure.
interface pixel_valid_if;
  import median_filter_pkg::*;

  pixel_t pixel;
  logic   valid;

  modport master (output pixel, output valid);
  modport slave  (input  pixel, input  valid);
endinterface

// File: rtl/raster_counter.sv
// Raster-order x/y position counter with end-of-line and end-of-frame flags.
import median_filter_pkg::*;

module raster_counter #(
  parameter int IMAGE_LEN    = 1080,
  parameter int IMAGE_HEIGHT = 720
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  output logic eol,
  output logic eof
);

  localparam int X_W = clog2_min1(IMAGE_LEN);
  localparam int Y_W = clog2_min1(IMAGE_HEIGHT);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMAGE_LEN - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMAGE_HEIGHT - 1);

  logic [X_W-1:0] x_reg;
  logic [Y_W-1:0] y_reg;

  assign eol = (x_reg == X_LAST);
  assign eof = eol && (y_reg == Y_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (clr) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (adv) begin
      if (eol) begin
        x_reg <= '0;
        // y parks on the last line; the next frame clears it explicitly.
        if (!eof) begin
          y_reg <= y_reg + Y_W'(1);
        end
      end else begin
        x_reg <= x_reg + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_pixel_streamer.sv
// Reads one frame from the frame buffer in raster order and streams it onto a
// pixel_valid_if master. FRAME_STREAMER_BLANKING_EN inserts H_BLANK idle cycles between lines.
import median_filter_pkg::*;

module frame_pixel_streamer #(
  parameter int IMAGE_LEN    = 1080,
  parameter int IMAGE_HEIGHT = 720,
  parameter int H_BLANK      = 4,
  parameter int MEM_ADDR_W   = clog2_min1(IMAGE_LEN * IMAGE_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  mem_en_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  input  logic [23:0]           mem_data_i,
  pixel_valid_if.master         pixel_valid_if_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // One down-counter serves both the drain wait and the line blanking gap.
  localparam int WAIT_MAX = (H_BLANK > MEM_LATENCY) ? H_BLANK : MEM_LATENCY;
  localparam int WAIT_W   = clog2_min1(WAIT_MAX + 1);

  streamer_state_t       state_reg, state_next;
  logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
  logic [MEM_ADDR_W-1:0] addr_reg, addr_next;
  logic [MEM_LATENCY:0]  valid_pipe_reg;
  pixel_t                pixel_reg;
  logic                  issue;
  logic                  clr;
  logic                  eol;
  logic                  eof;

  raster_counter #(
    .IMAGE_LEN    (IMAGE_LEN),
    .IMAGE_HEIGHT (IMAGE_HEIGHT)
  ) u_raster (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .adv (issue),
    .eol (eol),
    .eof (eof)
  );

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    addr_next     = addr_reg;
    issue         = 1'b0;
    clr           = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = ISSUE;
          addr_next  = '0;
          clr        = 1'b1;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (!eof) begin
          addr_next = addr_reg + MEM_ADDR_W'(1);
        end
        if (eof) begin
          state_next    = DRAIN;
          wait_cnt_next = WAIT_W'(MEM_LATENCY);
`ifdef FRAME_STREAMER_BLANKING_EN
        end else if (eol && (H_BLANK > 0)) begin
          state_next    = HBLANK;
          wait_cnt_next = WAIT_W'(H_BLANK - 1);
`endif
        end
      end
`ifdef FRAME_STREAMER_BLANKING_EN
      HBLANK: begin
        if (wait_cnt_reg == '0) begin
          state_next = ISSUE;
        end else begin
          wait_cnt_next = wait_cnt_reg - WAIT_W'(1);
        end
      end
`endif
      // Last read is in the memory, then in the output register, before DONE.
      DRAIN: begin
        if (wait_cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          wait_cnt_next = wait_cnt_reg - WAIT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= '0;
      addr_reg       <= '0;
      valid_pipe_reg <= '0;
      pixel_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      addr_reg       <= addr_next;
      valid_pipe_reg <= {valid_pipe_reg[MEM_LATENCY-1:0], issue};
      // Load only when read data is live so the pixel holds steady while invalid.
      if (valid_pipe_reg[MEM_LATENCY-1]) begin
        pixel_reg <= unpack_pixel(mem_data_i);
      end
    end
  end

  assign mem_en_o               = (state_reg == ISSUE);
  assign mem_addr_o             = addr_reg;
  assign busy_o                 = (state_reg != IDLE);
  assign done_o                 = (state_reg == DONE);
  assign pixel_valid_if_o.pixel = pixel_reg;
  assign pixel_valid_if_o.valid = valid_pipe_reg[MEM_LATENCY];

endmodule

// File: doc/frame_pixel_streamer.md
Name: frame_pixel_streamer

Overview:
Transmit side of the pixel_valid_if link that feeds the median filter. On a start pulse it reads one full frame from a word-addressed frame memory in raster order (row 0 first, left to right) and drives each pixel onto a pixel_valid_if master. It raises done_o after the last pixel and has no backpressure; the consumer accepts any valid pixel. It sits between the frame buffer BRAM and median_filter's slave port.

Parameters:
IMAGE_LEN, 1080, pixels per line
IMAGE_HEIGHT, 720, lines per frame
H_BLANK, 4, idle cycles inserted between lines (used only with FRAME_STREAMER_BLANKING_EN)
MEM_ADDR_W, $clog2(IMAGE_LEN*IMAGE_HEIGHT), frame memory address width (derived)

Ports:
clk  input  1  clock; single domain
rst  input  1  asynchronous, active-high reset
start_i  input  1  frame start request; sampled on clk
mem_en_o  output  1  frame memory read enable
mem_addr_o  output  MEM_ADDR_W  frame memory read address (pixel index y*IMAGE_LEN+x)
mem_data_i  input  24  read data, {red[23:16], green[15:8], blue[7:0]}; valid exactly 1 cycle after mem_en_o
pixel_valid_if_o  master  pixel_t+1  .pixel (red/green/blue, 8b each), .valid
busy_o  output  1  high while a frame is in flight
done_o  output  1  one-cycle pulse after the last pixel

Behaviour:
- Interface decision: one clock, clk. rst is asynchronous and active-high. All flops clear immediately when rst asserts.
- Reset values: valid=0, pixel=0, mem_en_o=0, mem_addr_o=0, busy_o=0, done_o=0, state=IDLE, x=0, y=0.
- FSM states:
  - IDLE -> ISSUE when start_i=1.
  - ISSUE: mem_en_o=1 each cycle; raster counters advance.
  - ISSUE -> DRAIN after the address of the last pixel is issued.
  - DRAIN: waits for the in-flight reads to emerge, then -> DONE.
  - DONE: done_o=1 for one cycle, then -> IDLE unconditionally.
- start_i is honoured only in IDLE. It is ignored in ISSUE, DRAIN and DONE, including the done_o cycle. No queuing.
- Latency:
  - start_i sampled at edge E0.
  - Address 0 issued in the cycle after E0.
  - mem_data_i returns one cycle later.
  - Output register drives pixel 0 with valid=1 in the third cycle after the start_i cycle.
  - Each subsequent pixel follows in the next cycle.
- Output pixel is registered. Unpacking: red=mem_data_i[23:16], green=[15:8], blue=[7:0].
- Valid is delayed through a 2-stage shift register aligned with the memory latency. Pixel must never change while valid=0 except at reset.
- Counters:
  - x wraps IMAGE_LEN-1 -> 0 and increments y.
  - y terminates at IMAGE_HEIGHT-1; no wrap within a frame.
  - mem_addr_o increments by 1 per issued read and resets to 0 on each new frame.
- Total valid cycles per frame: exactly IMAGE_LEN*IMAGE_HEIGHT.
- done_o asserts in the cycle immediately after the last valid pixel.
- busy_o=1 from the cycle after start_i acceptance through the done_o cycle inclusive.
- Reset mid-frame: outputs drop asynchronously and no done_o is produced. The next start streams from pixel 0.
- 1xN and Nx1 images must work (IMAGE_LEN or IMAGE_HEIGHT = 1).

Optional Feature:
FRAME_STREAMER_BLANKING_EN
- Defined: after the last pixel of every line except the final line, the FSM enters HBLANK for H_BLANK cycles with mem_en_o=0. The output therefore shows exactly H_BLANK valid=0 cycles between lines. done_o timing relative to the last pixel is unchanged.
- Undefined: no HBLANK state; the frame streams as one contiguous valid burst.

Decomposition:
- Shared package median_filter_pkg:
  - pixel_t (existing)
  - streamer_state_t enum {IDLE, ISSUE, HBLANK, DRAIN, DONE}
  - MEM_LATENCY=1 constant
  - pack/unpack functions between pixel_t and 24b
- Sub-module raster_counter (x/y counters, end-of-line/end-of-frame flags, advance enable, synchronous clear).

Test Plan:
1. IMAGE_LEN=4, IMAGE_HEIGHT=3, mem[k]={k, k+16, k+32}, start pulse -> 12 consecutive valids starting 3 cycles after start. Pixel0 = (0,16,32), pixel11 = (11,27,43). done_o one pulse the cycle after pixel11. busy_o drops with done.
2. Same config, second start_i 5 cycles into frame and again on the done_o cycle -> exactly 12 valids, one done_o, state returns to IDLE.
3. start_i in first IDLE cycle after done -> second frame of 12 pixels begins 3 cycles later; 24 valids and 2 done pulses total.
4. Assert rst after pixel4 is output -> valid, busy_o and mem_en_o go 0 without waiting for clk; no done_o. Next start yields pixel0 = (0,16,32) and a full 12-pixel frame.
5. With FRAME_STREAMER_BLANKING_EN, H_BLANK=4 -> exactly 4 idle cycles between pixel3/pixel4 and between pixel7/pixel8. No gap after pixel11; done_o the cycle after pixel11; 12 valids total.
6. Default 1080x720, mem[k]=k[23:0] -> 777600 valids, every pixel equals its index, single done_o.
